// File: rtl/vce_cram_arbiter.sv
// VCE colour-RAM port arbiter.
// Shares one single-port CRAM between the pixel fetch pipeline and CPU
// accesses. The CPU gets free slots (no pixel, or blanking). After
// STARVE_MAX pixel slots have gone by with a CPU access waiting, the CPU
// takes the next pixel slot, and that pixel is flagged as an artifact.
module vce_cram_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic       clock,
   input  logic       reset_N,
   input  logic       pix_en,
   input  logic [8:0] pix_addr,
   input  logic       blank,
   output logic [8:0] pix_data,
   output logic       pix_valid,
   output logic       pix_artifact,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [8:0] cpu_addr,
   input  logic [8:0] cpu_wdata,
   output logic       cpu_ack,
   output logic [8:0] cpu_rdata,
   output logic       busy,
   output logic       overrun,
   output logic [8:0] ram_addr,
   output logic       ram_we,
   output logic [8:0] ram_wdata,
   input  logic [8:0] ram_rdata
);

   // The starve counter is 3 bits wide, so the limit must fit in 3 bits.
   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_RDWAIT
   } state_t;

   state_t     state;
   logic [2:0] starve;
   logic       pend_we;
   logic [8:0] pend_addr;
   logic [8:0] pend_wdata;

   logic       pix_slot;
   logic       pix_grant;
   logic       cpu_grant;

   logic       fetch_v;
   logic       fetch_steal;

   // Pick the single owner of the CRAM port for this cycle.
   always_comb begin
      pix_slot  = pix_en & ~blank;
      pix_grant = pix_slot & (starve < STARVE_LIM);
      cpu_grant = ~pix_grant & (state == ST_PEND);
      ram_addr  = cpu_grant ? pend_addr : pix_addr;
      ram_we    = cpu_grant & pend_we;
      ram_wdata = pend_wdata;
   end

   // CPU request FSM: capture, wait for a slot, complete, with registered outputs.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         state      <= ST_IDLE;
         starve     <= '0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         cpu_ack    <= 1'b0;
         cpu_rdata  <= '0;
         pend_we    <= 1'b0;
         pend_addr  <= '0;
         pend_wdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         if (cpu_req && busy) begin
            overrun <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               starve <= '0;
               if (cpu_req) begin
                  pend_we    <= cpu_we;
                  pend_addr  <= cpu_addr;
                  pend_wdata <= cpu_wdata;
                  busy       <= 1'b1;
                  state      <= ST_PEND;
               end
            end
            ST_PEND: begin
               if (cpu_grant) begin
                  starve <= '0;
                  if (pend_we) begin
                     cpu_ack <= 1'b1;
                     busy    <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     state <= ST_RDWAIT;
                  end
               end else if (pix_grant) begin
                  // pix_grant already implies starve < STARVE_LIM, so this saturates.
                  starve <= starve + 3'd1;
               end
            end
            ST_RDWAIT: begin
               starve    <= '0;
               cpu_rdata <= ram_rdata;
               cpu_ack   <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               starve <= '0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   // Pixel pipeline: slot marker in stage 1, colour word and flags in stage 2.
   always_ff @(posedge clock or negedge reset_N) begin
      if (!reset_N) begin
         fetch_v      <= 1'b0;
         fetch_steal  <= 1'b0;
         pix_valid    <= 1'b0;
         pix_artifact <= 1'b0;
         pix_data     <= '0;
      end else begin
         fetch_v      <= pix_slot;
         fetch_steal  <= pix_slot & ~pix_grant;
         pix_valid    <= fetch_v;
         pix_artifact <= fetch_v & fetch_steal;
         // A stolen slot re-issues the previous colour word unchanged.
         if (fetch_v && !fetch_steal) begin
            pix_data <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vce_cram_arbiter.sv
// Self-checking bench for vce_cram_arbiter: directed scenarios with literal
// expectations plus a randomized run checked every cycle against an
// event-scheduling reference model.
module tb_vce_cram_arbiter;

   localparam int unsigned STARVE_MAX = 4;

   logic       clock = 1'b0;
   logic       reset_N = 1'b0;
   logic       pix_en = 1'b0;
   logic [8:0] pix_addr = '0;
   logic       blank = 1'b0;
   logic [8:0] pix_data;
   logic       pix_valid;
   logic       pix_artifact;
   logic       cpu_req = 1'b0;
   logic       cpu_we = 1'b0;
   logic [8:0] cpu_addr = '0;
   logic [8:0] cpu_wdata = '0;
   logic       cpu_ack;
   logic [8:0] cpu_rdata;
   logic       busy;
   logic       overrun;
   logic [8:0] ram_addr;
   logic       ram_we;
   logic [8:0] ram_wdata;
   logic [8:0] ram_rdata = '0;

   vce_cram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clock       (clock),
      .reset_N     (reset_N),
      .pix_en      (pix_en),
      .pix_addr    (pix_addr),
      .blank       (blank),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_artifact(pix_artifact),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ack     (cpu_ack),
      .cpu_rdata   (cpu_rdata),
      .busy        (busy),
      .overrun     (overrun),
      .ram_addr    (ram_addr),
      .ram_we      (ram_we),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit started = 1'b0;

   // CRAM: synchronous read of the old word, write takes effect at the edge.
   logic [8:0] ram [512];
   always @(posedge clock) begin
      ram_rdata <= ram[ram_addr];
      if (ram_we) ram[ram_addr] = ram_wdata;
   end

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk9(input string nm, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%03h expected 0x%03h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: CRAM contents, the waiting CPU access, and future
   // output events kept in an 8-deep ring indexed by cycle number.
   logic [8:0] ref_mem [512];
   bit         m_pend = 1'b0;
   bit         m_we = 1'b0;
   logic [8:0] m_addr = '0;
   logic [8:0] m_wdata = '0;
   int         m_release = 0;
   int         m_waits = 0;
   bit         m_over = 1'b0;
   logic [8:0] m_pix = '0;
   logic [8:0] m_rd = '0;
   bit         s_pv [8];
   bit         s_art [8];
   bit         s_ack [8];
   bit         s_pdu [8];
   bit         s_rdu [8];
   logic [8:0] s_pdv [8];
   logic [8:0] s_rdv [8];

   always @(negedge clock) begin
      int k;
      int k1;
      int k2;
      bit busy_now;
      bit slot;
      bit pg;
      bit cg;
      if (started) begin
         k  = cyc % 8;
         k1 = (cyc + 1) % 8;
         k2 = (cyc + 2) % 8;
         if (!reset_N) begin
            m_pend = 1'b0; m_waits = 0; m_over = 1'b0; m_release = cyc;
            m_pix = '0; m_rd = '0;
            for (int i = 0; i < 8; i++) begin
               s_pv[i] = 1'b0; s_art[i] = 1'b0; s_ack[i] = 1'b0;
               s_pdu[i] = 1'b0; s_rdu[i] = 1'b0;
            end
            chk1("rst_pix_valid", pix_valid, 1'b0);
            chk1("rst_pix_artifact", pix_artifact, 1'b0);
            chk9("rst_pix_data", pix_data, 9'h000);
            chk1("rst_cpu_ack", cpu_ack, 1'b0);
            chk9("rst_cpu_rdata", cpu_rdata, 9'h000);
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_overrun", overrun, 1'b0);
            chk1("rst_ram_we", ram_we, 1'b0);
            chk9("rst_ram_addr", ram_addr, pix_addr);
         end else begin
            if (s_pdu[k]) m_pix = s_pdv[k];
            if (s_rdu[k]) m_rd = s_rdv[k];
            busy_now = m_pend || (cyc < m_release);
            slot = pix_en && !blank;
            pg = slot && (m_waits < STARVE_MAX);
            cg = !pg && m_pend;
            chk9("ram_addr", ram_addr, cg ? m_addr : pix_addr);
            chk1("ram_we", ram_we, cg && m_we);
            if (cg && m_we) chk9("ram_wdata", ram_wdata, m_wdata);
            chk1("pix_valid", pix_valid, s_pv[k]);
            if (s_pv[k]) chk1("pix_artifact", pix_artifact, s_art[k]);
            chk9("pix_data", pix_data, m_pix);
            chk1("cpu_ack", cpu_ack, s_ack[k]);
            chk9("cpu_rdata", cpu_rdata, m_rd);
            chk1("busy", busy, busy_now);
            chk1("overrun", overrun, m_over);
            s_pv[k] = 1'b0; s_art[k] = 1'b0; s_ack[k] = 1'b0;
            s_pdu[k] = 1'b0; s_rdu[k] = 1'b0;
            // Every non-blanked pixel slot yields a pulse two cycles later.
            if (slot) begin
               s_pv[k2] = 1'b1;
               s_art[k2] = !pg;
               if (pg) begin
                  s_pdu[k2] = 1'b1;
                  s_pdv[k2] = ref_mem[pix_addr];
               end
            end
            if (cg) begin
               m_pend = 1'b0;
               m_waits = 0;
               if (m_we) begin
                  ref_mem[m_addr] = m_wdata;
                  s_ack[k1] = 1'b1;
                  m_release = cyc + 1;
               end else begin
                  s_ack[k2] = 1'b1;
                  s_rdu[k2] = 1'b1;
                  s_rdv[k2] = ref_mem[m_addr];
                  m_release = cyc + 2;
               end
            end else if (pg && m_pend) begin
               m_waits++;
            end
            if (cpu_req) begin
               if (busy_now) begin
                  m_over = 1'b1;
               end else begin
                  m_pend = 1'b1;
                  m_we = cpu_we;
                  m_addr = cpu_addr;
                  m_wdata = cpu_wdata;
               end
            end
         end
      end
      cyc++;
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
      #1;
   endtask

   logic [8:0] pa [5];
   int dens;
   int bl;

   initial begin
      for (int i = 0; i < 512; i++) begin
         ref_mem[i] = 9'($urandom);
         ram[i] = ref_mem[i];
      end

      // Reset values
      next_cycle();
      started = 1'b1;
      next_cycle();
      mid();
      chk1("lit_reset_busy", busy, 1'b0);
      chk1("lit_reset_overrun", overrun, 1'b0);
      chk1("lit_reset_valid", pix_valid, 1'b0);
      chk9("lit_reset_pix_data", pix_data, 9'h000);

      // Write 0x1C7 to 0x005 during blanking, then read it back
      next_cycle();
      reset_N = 1'b1; blank = 1'b1; pix_en = 1'b1; pix_addr = 9'h010;
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h005; cpu_wdata = 9'h1C7;
      next_cycle();
      cpu_req = 1'b0;
      mid();
      chk1("lit_wr_ram_we", ram_we, 1'b1);
      chk9("lit_wr_ram_addr", ram_addr, 9'h005);
      chk9("lit_wr_ram_wdata", ram_wdata, 9'h1C7);
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
      mid();
      chk1("lit_wr_ack", cpu_ack, 1'b1);
      chk1("lit_wr_busy_low", busy, 1'b0);
      next_cycle();
      cpu_req = 1'b0;
      mid();
      chk9("lit_rd_grant_addr", ram_addr, 9'h005);
      chk1("lit_rd_grant_we", ram_we, 1'b0);
      next_cycle();
      mid();
      chk1("lit_rd_no_early_ack", cpu_ack, 1'b0);
      next_cycle();
      mid();
      chk1("lit_rd_ack", cpu_ack, 1'b1);
      chk9("lit_rd_data", cpu_rdata, 9'h1C7);
      chk1("lit_rd_busy_low", busy, 1'b0);

      // Pixels every cycle: four pixel grants, then the CPU steals the fifth
      next_cycle();
      blank = 1'b0; pix_en = 1'b1; pix_addr = 9'($urandom_range(0, 255));
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h1FF;
      for (int i = 1; i <= 4; i++) begin
         next_cycle();
         cpu_req = 1'b0;
         pix_addr = 9'($urandom_range(0, 255));
         pa[i] = pix_addr;
         mid();
         chk9("lit_starve_pix_grant", ram_addr, pa[i]);
      end
      next_cycle();
      pix_addr = 9'($urandom_range(0, 255));
      mid();
      chk9("lit_starve_cpu_grant", ram_addr, 9'h1FF);
      next_cycle();
      pix_addr = 9'($urandom_range(0, 255));
      next_cycle();
      mid();
      chk1("lit_steal_valid", pix_valid, 1'b1);
      chk1("lit_steal_artifact", pix_artifact, 1'b1);
      chk9("lit_steal_data_held", pix_data, ram[pa[4]]);
      chk1("lit_steal_ack", cpu_ack, 1'b1);
      chk9("lit_steal_rdata", cpu_rdata, ram[9'h1FF]);

      // Pixels every 4th cycle: the write lands in a free slot
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         pix_en = (i % 4 == 0);
         pix_addr = 9'($urandom_range(0, 255));
         cpu_req = (i == 1); cpu_we = 1'b1;
         cpu_addr = 9'h100 | 9'($urandom_range(0, 200)); cpu_wdata = 9'($urandom);
         mid();
         if (i == 2) chk1("lit_free_slot_we", ram_we, 1'b1);
         chk1("lit_no_artifact", pix_artifact, 1'b0);
      end

      // Back-to-back requests: second one ignored, overrun sticks
      next_cycle();
      pix_en = 1'b0; blank = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h0A0; cpu_wdata = 9'h055;
      next_cycle();
      cpu_wdata = 9'h0AA;
      mid();
      chk9("lit_ovr_first_wdata", ram_wdata, 9'h055);
      chk1("lit_ovr_not_yet", overrun, 1'b0);
      next_cycle();
      cpu_req = 1'b0;
      mid();
      chk1("lit_ovr_set", overrun, 1'b1);
      chk1("lit_ovr_first_ack", cpu_ack, 1'b1);
      repeat (3) next_cycle();
      mid();
      chk1("lit_ovr_sticky", overrun, 1'b1);
      chk1("lit_ovr_no_second_ack", cpu_ack, 1'b0);

      // Reset while the read is in RDWAIT
      next_cycle();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h005;
      next_cycle();
      cpu_req = 1'b0;
      next_cycle();
      reset_N = 1'b0;
      mid();
      chk1("lit_rdwait_rst_busy", busy, 1'b0);
      chk1("lit_rdwait_rst_overrun", overrun, 1'b0);
      next_cycle();
      next_cycle();
      reset_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk1("lit_rst_no_ack", cpu_ack, 1'b0);
         chk1("lit_rst_no_valid", pix_valid, 1'b0);
         next_cycle();
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h0A0;
      next_cycle();
      cpu_req = 1'b0;
      next_cycle();
      next_cycle();
      mid();
      chk1("lit_post_rst_ack", cpu_ack, 1'b1);
      chk9("lit_post_rst_rdata", cpu_rdata, 9'h055);

      // Randomized traffic across pixel densities and blanking ratios
      for (int seg = 0; seg < 12; seg++) begin
         dens = seg % 4;
         bl = (seg / 4 == 0) ? 0 : ((seg / 4 == 1) ? 2 : 5);
         for (int i = 0; i < 200; i++) begin
            next_cycle();
            case (dens)
               0: pix_en = 1'b1;
               1: pix_en = (i % 2 == 0);
               2: pix_en = (i % 4 == 0);
               default: pix_en = 1'($urandom_range(0, 1));
            endcase
            blank = ($urandom_range(0, 9) < bl);
            pix_addr = 9'($urandom_range(0, 15));
            cpu_req = ($urandom_range(0, 4) == 0);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 9'($urandom_range(0, 15));
            cpu_wdata = 9'($urandom);
            reset_N = ($urandom_range(0, 299) != 0);
         end
      end

      next_cycle();
      reset_N = 1'b1; cpu_req = 1'b0;
      repeat (4) next_cycle();
      mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
